// File: rtl/traffic_pkg.sv
// Shared definitions for the rule-184 traffic flow monitor: FSM states,
// default geometry and counter-width helpers.
package traffic_pkg;

    localparam int N_DEF      = 20;  // ring length
    localparam int WARMUP_DEF = 8;   // step samples discarded before measuring
    localparam int WINDOW_DEF = 16;  // step samples accumulated

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_MEASURE,
        S_DONE
    } mon_state_e;

    // Bits needed to hold any count in 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/traffic_flow_monitor_if.sv
// Bus between the automaton (master) and the flow monitor (slave): the step
// strobe and cell vector in, measurement status and results out.
interface traffic_flow_monitor_if
    import traffic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int WINDOW = WINDOW_DEF
);
    localparam int DENS_W = cnt_w(N);
    localparam int FLUX_W = cnt_w(N * WINDOW);
    localparam int PER_W  = cnt_w(WINDOW);

    logic              start;
    logic              step_en;
    logic [N-1:0]      state;
    logic              busy;
    logic              done;
    logic [DENS_W-1:0] density;
    logic [FLUX_W-1:0] flux_sum;
    logic              free_flow;
    logic              jam;
    logic              cons_err;
    logic [PER_W-1:0]  period;

    modport master (
        output start, step_en, state,
        input  busy, done, density, flux_sum, free_flow, jam, cons_err, period
    );

    modport slave (
        input  start, step_en, state,
        output busy, done, density, flux_sum, free_flow, jam, cons_err, period
    );

endinterface

// File: rtl/flow_step_counter.sv
// Per-step statistics of one automaton state: number of cars and number of
// cars able to move (car with an empty cell ahead, wrapping bit N-1 -> bit 0).
module flow_step_counter
    import traffic_pkg::*;
#(
    parameter  int N  = N_DEF,
    localparam int CW = cnt_w(N)
) (
    input  logic [N-1:0]  i_state,
    output logic [CW-1:0] o_popcount,
    output logic [CW-1:0] o_flux
);

    // Count occupied cells and occupied cells followed by a free cell.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        o_popcount = '0;
        o_flux     = '0;
        for (int i = 0; i < N; i++) begin
            o_popcount = o_popcount + CW'(i_state[i]);
            if (i_state[i] && !i_state[(i + 1) % N])
                o_flux = o_flux + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_flow_monitor.sv
// Flow monitor at the output of the rule-184 ring: skips WARMUP steps, then
// over WINDOW steps accumulates flux, latches density and checks car
// conservation, free flow and jamming.
// Optional: TRAFFIC_PERIOD_DETECT_EN adds recurrence-period detection of the
// first window sample; without it period is constant 0.
module traffic_flow_monitor
    import traffic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int WARMUP = WARMUP_DEF,
    parameter int WINDOW = WINDOW_DEF
) (
    input logic                  clk,
    input logic                  res,
    traffic_flow_monitor_if.slave bus
);

    localparam int DENS_W    = cnt_w(N);
    localparam int FLUX_W    = cnt_w(N * WINDOW);
    localparam int PER_W     = cnt_w(WINDOW);
    localparam int CNT_MAX   = (WARMUP > WINDOW) ? WARMUP : WINDOW;
    localparam int CNT_W     = cnt_w(CNT_MAX);
    localparam int WARM_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;
    localparam int WIN_LAST  = WINDOW - 1;

    mon_state_e        r_state;
    mon_state_e        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DENS_W-1:0] w_pop;
    logic [DENS_W-1:0] w_flux;
    logic [DENS_W-1:0] r_density;
    logic [FLUX_W-1:0] r_flux_sum;
    logic              r_free_flow;
    logic              r_jam;
    logic              r_cons_err;
    logic              w_start_ok;
    logic              w_measure_step;
    logic              w_first;
    logic              w_warm_last;
    logic              w_win_last;

    flow_step_counter #(.N(N)) u_step_counter (
        .i_state    (bus.state),
        .o_popcount (w_pop),
        .o_flux     (w_flux)
    );

    assign w_start_ok     = (r_state == S_IDLE) && bus.start;
    assign w_measure_step = (r_state == S_MEASURE) && bus.step_en;
    assign w_first        = (r_cnt == '0);
    assign w_warm_last    = (r_cnt == CNT_W'(WARM_LAST));
    assign w_win_last     = (r_cnt == CNT_W'(WIN_LAST));

    // FSM state register.
    always_ff @(posedge clk or negedge res) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!res) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // FSM next-state: only qualified steps advance warm-up and window.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (bus.start) w_next = (WARMUP == 0) ? S_MEASURE : S_WARMUP;
            S_WARMUP:  if (bus.step_en && w_warm_last) w_next = S_MEASURE;
            S_MEASURE: if (bus.step_en && w_win_last) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Step-sample counter, shared by warm-up and window phases.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_cnt <= '0;
        end else if ((r_state == S_WARMUP) || (r_state == S_MEASURE)) begin
            if (bus.step_en) begin
                if ((r_state == S_WARMUP) ? w_warm_last : w_win_last) r_cnt <= '0;
                else                                                  r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Window accumulators and sticky flags, cleared on an accepted start.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_density   <= '0;
            r_flux_sum  <= '0;
            r_free_flow <= 1'b0;
            r_jam       <= 1'b0;
            r_cons_err  <= 1'b0;
        end else if (w_start_ok) begin
            r_flux_sum  <= '0;
            r_free_flow <= 1'b1;
            r_jam       <= 1'b0;
            r_cons_err  <= 1'b0;
        end else if (w_measure_step) begin
            r_flux_sum <= r_flux_sum + FLUX_W'(w_flux);
            if (w_first)                r_density   <= w_pop;
            else if (w_pop != r_density) r_cons_err <= 1'b1;
            if (w_flux != w_pop)        r_free_flow <= 1'b0;
            if ((w_flux == '0) && (w_pop != '0)) r_jam <= 1'b1;
        end
    end

`ifdef TRAFFIC_PERIOD_DETECT_EN
    logic [N-1:0]     r_snap;
    logic [PER_W-1:0] r_period;

    // Snapshot the first window sample and record the first later index that repeats it.
    always_ff @(posedge clk or negedge res) begin
        // NOTE: the snapshot is a plain register, so it takes the async reset like any other flop.
        if (!res) begin
            r_snap   <= '0;
            r_period <= '0;
        end else if (w_start_ok) begin
            r_period <= '0;
        end else if (w_measure_step) begin
            if (w_first)
                r_snap <= bus.state;
            else if ((r_period == '0) && (bus.state == r_snap))
                r_period <= PER_W'(r_cnt);
        end
    end

    assign bus.period = r_period;
`else
    assign bus.period = '0;
`endif

    assign bus.busy      = (r_state == S_WARMUP) || (r_state == S_MEASURE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.density   = r_density;
    assign bus.flux_sum  = r_flux_sum;
    assign bus.free_flow = r_free_flow;
    assign bus.jam       = r_jam;
    assign bus.cons_err  = r_cons_err;

endmodule

// File: tb/tb_traffic_flow_monitor.sv
// Scoreboard bench for traffic_flow_monitor: a rule-184 model generates each
// measurement's step samples and expected results, pushed at start and
// compared when done pulses.
module tb_traffic_flow_monitor;
    import traffic_pkg::*;

    localparam int N      = N_DEF;
    localparam int WARMUP = WARMUP_DEF;
    localparam int WINDOW = WINDOW_DEF;
    localparam int TOTAL  = WARMUP + WINDOW;

    typedef struct {
        int density;
        int flux;
        int ff;
        int jam;
        int cons;
        int period;
    } exp_t;

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    traffic_flow_monitor_if #(.N(N), .WINDOW(WINDOW)) bus ();

    traffic_flow_monitor #(.N(N), .WARMUP(WARMUP), .WINDOW(WINDOW)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, required %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int popc(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int flux_of(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) if (v[i] && !v[(i + 1) % N]) c++;
        return c;
    endfunction

    function automatic logic [N-1:0] r184(input logic [N-1:0] v);
        logic [N-1:0] nx;
        for (int j = 0; j < N; j++) begin
            logic prv, cur, nxt;
            prv   = v[(j + N - 1) % N];
            cur   = v[j];
            nxt   = v[(j + 1) % N];
            nx[j] = (prv & ~cur) | (cur & nxt);
        end
        return nx;
    endfunction

    // Scoreboard: every done pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (res && bus.done) begin
            n_done++;
            check("sb_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("density",   32'(bus.density),   32'(mon_e.density));
                check("flux_sum",  32'(bus.flux_sum),  32'(mon_e.flux));
                check("free_flow", 32'(bus.free_flow), 32'(mon_e.ff));
                check("jam",       32'(bus.jam),       32'(mon_e.jam));
                check("cons_err",  32'(bus.cons_err),  32'(mon_e.cons));
                check("period",    32'(bus.period),    32'(mon_e.period));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(bus.busy),      0);
        check({tag, "_done"},      32'(bus.done),      0);
        check({tag, "_density"},   32'(bus.density),   0);
        check({tag, "_flux_sum"},  32'(bus.flux_sum),  0);
        check({tag, "_free_flow"}, 32'(bus.free_flow), 0);
        check({tag, "_jam"},       32'(bus.jam),       0);
        check({tag, "_cons_err"},  32'(bus.cons_err),  0);
        check({tag, "_period"},    32'(bus.period),    0);
    endtask

    // One measurement: drop_at removes a car at that window sample (0-based),
    // abort_at asserts reset during that window sample, gap spaces step_en.
    task automatic run_case(input logic [N-1:0] init, input bit hold, input int gap,
                            input int drop_at, input int abort_at, input bit extra_start);
        logic [N-1:0] vec [TOTAL];
        logic [N-1:0] cur;
        exp_t         e;
        int           done_base;
        int           lat;

        cur = init;
        for (int j = 0; j < TOTAL; j++) begin
            if (j - WARMUP == drop_at) cur = cur & (cur - 1'b1);
            vec[j] = cur;
            cur    = hold ? cur : r184(cur);
        end

        e.density = popc(vec[WARMUP]);
        e.flux = 0; e.ff = 1; e.jam = 0; e.cons = 0; e.period = 0;
        for (int m = 0; m < WINDOW; m++) begin
            logic [N-1:0] v;
            int f, p;
            v = vec[WARMUP + m];
            f = flux_of(v);
            p = popc(v);
            e.flux += f;
            if (m > 0 && p != e.density) e.cons = 1;
            if (f != p) e.ff = 0;
            if (f == 0 && p > 0) e.jam = 1;
            if (m > 0 && e.period == 0 && v == vec[WARMUP]) e.period = m;
        end
`ifndef TRAFFIC_PERIOD_DETECT_EN
        e.period = 0;
`endif
        if (abort_at < 0) sb.push_back(e);

        // Start cycle carries a junk step that must not be counted.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.step_en = 1'b1;
        bus.state   = ~init;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.step_en = 1'b0;
        check("busy_after_start", 32'(bus.busy), 1);
        done_base = n_done;

        for (int j = 0; j < TOTAL; j++) begin
            for (int g = 1; g < gap; g++) begin
                bus.step_en = 1'b0;
                @(negedge clk);
            end
            if (j == TOTAL - 1) check("no_early_done", 32'(n_done - done_base), 0);
            bus.step_en = 1'b1;
            bus.state   = vec[j];
            bus.start   = extra_start && (j == 3);
            if (abort_at >= 0 && j == WARMUP + abort_at) begin
                #2 res = 1'b0;
                #1 check_all_zero("abort");
                @(negedge clk);
                res         = 1'b1;
                bus.step_en = 1'b0;
                bus.start   = 1'b0;
                #1 check("idle_after_abort", 32'(bus.busy), 0);
                return;
            end
            @(negedge clk);
        end
        bus.step_en = 1'b0;
        bus.start   = 1'b0;

        #1;
        lat = 1;
        while (n_done == done_base && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("done_latency", 32'(lat), 1);
        @(negedge clk);
        #1;
        check("done_pulse", 32'(bus.done), 0);
        check("busy_after_done", 32'(bus.busy), 0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.step_en = 1'b0;
        bus.state   = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        res = 1'b1;

        run_case(20'b10101010101010101010, 1'b0, 1, -1, -1, 1'b0);  // density 0.5
        run_case(20'b11111101011011001110, 1'b0, 1, -1, -1, 1'b0);  // density 0.7
        run_case('1,                       1'b1, 1, -1, -1, 1'b0);  // full ring, jammed
        run_case(20'b00000010100100110001, 1'b0, 1,  4, -1, 1'b0);  // density 0.3, car lost
        run_case('0,                       1'b1, 1, -1, -1, 1'b0);  // empty ring
        run_case(20'b10101010101010101010, 1'b0, 1, -1,  6, 1'b0);  // reset mid-window
        run_case(20'b11111101011011001110, 1'b0, 1, -1, -1, 1'b0);  // clean rerun after abort
        run_case(20'b00000010100100110001, 1'b0, 3, -1, -1, 1'b1);  // gapped steps, extra start

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
